// File: rtl/pi_stimulus_core_pkg.sv
// rtl/pi_stimulus_core_pkg.sv - shared types and widths for the PI stimulus compute stage
// Contents: controller state enum, datapath width constants, parameter defaults.
package pi_stimulus_core_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ERR   = 3'd1,
        MUL_P = 3'd2,
        MUL_I = 3'd3,
        SUM   = 3'd4
    } state_t;

    localparam int ERR_W   = 9;   // sp - pv, signed, -255..255
    localparam int INTEG_W = 12;  // saturating integral, signed
    localparam int ACC_W   = 21;  // multiply accumulator, signed
    localparam int CNT_W   = 3;   // multiplier bit index 0..7

    localparam int DEF_FRAC_BITS = 4;
    localparam int DEF_INT_LIMIT = 2047;

endpackage

// File: rtl/pi_stimulus_core_if.sv
// rtl/pi_stimulus_core_if.sv - sample-in / stimulus-out bundle of the PI compute stage
// Ports: pv_stb, sp, pv, kp, ki (toward the core); stimulus, stim_stb, busy (from the core).
interface pi_stimulus_core_if;
    logic       pv_stb;
    logic [7:0] sp;
    logic [7:0] pv;
    logic [7:0] kp;
    logic [7:0] ki;
    logic [7:0] stimulus;
    logic       stim_stb;
    logic       busy;

    modport master (
        output pv_stb, sp, pv, kp, ki,
        input  stimulus, stim_stb, busy
    );

    modport slave (
        input  pv_stb, sp, pv, kp, ki,
        output stimulus, stim_stb, busy
    );
endinterface

// File: rtl/pi_stimulus_core_shift_add_mac.sv
// rtl/pi_stimulus_core_shift_add_mac.sv - bit-serial shift-add multiply-accumulate
// Ports: clk, reset; clear (zero acc), start (begin 8-step pass), mcand (signed),
//        mplier (unsigned 8-bit); acc (signed accumulator), done (high on the last step).
module shift_add_mac
    import pi_stimulus_core_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      start,
    input  logic signed [INTEG_W-1:0] mcand,
    input  logic        [7:0]         mplier,
    output logic signed [ACC_W-1:0]   acc,
    output logic                      done
);
    logic [CNT_W-1:0]         cnt;
    logic                     active;
    logic signed [ACC_W-1:0]  mcand_ext;
    logic signed [ACC_W-1:0]  addend;

    always_comb begin
        mcand_ext = {{(ACC_W-INTEG_W){mcand[INTEG_W-1]}}, mcand};
        addend    = mcand_ext <<< cnt;
        done      = active && (cnt == {CNT_W{1'b1}});
    end

    // A start on the final step of one pass chains straight into the next pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            if (clear)
                acc <= '0;
            else if (active && mplier[cnt])
                acc <= acc + addend;

            if (start) begin
                cnt    <= '0;
                active <= 1'b1;
            end else if (active) begin
                cnt <= cnt + 1'b1;
                if (cnt == {CNT_W{1'b1}})
                    active <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pi_stimulus_core.sv
// rtl/pi_stimulus_core.sv - sequential fixed-point PI stage producing an 8-bit stimulus
// Ports: clk, reset (sync, active-high); bus (slave): pv_stb/sp/pv/kp/ki in,
//        stimulus/stim_stb/busy out.
module pi_stimulus_core
    import pi_stimulus_core_pkg::*;
#(
    parameter int FRAC_BITS = DEF_FRAC_BITS,
    parameter int INT_LIMIT = DEF_INT_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    pi_stimulus_core_if.slave  bus
);
    localparam logic signed [INTEG_W:0]  LIM_P    = (INTEG_W+1)'(INT_LIMIT);
    localparam logic signed [INTEG_W:0]  LIM_N    = -LIM_P;
    localparam logic signed [ACC_W-1:0]  STIM_MAX = ACC_W'(255);

    state_t                     state;
    logic [7:0]                 sp_q, pv_q, kp_q, ki_q;
    logic signed [ERR_W-1:0]    e_q, e_calc;
    logic signed [INTEG_W-1:0]  integ_q;
    logic signed [INTEG_W:0]    integ_sum, integ_sat;
    logic [7:0]                 stimulus_q;
    logic                       stim_stb_q;

    logic                       mac_clear, mac_start, mac_done;
    logic signed [INTEG_W-1:0]  mac_mcand;
    logic [7:0]                 mac_mplier;
    logic signed [ACC_W-1:0]    mac_acc;
    logic signed [ACC_W-1:0]    r;

    always_comb begin
        e_calc    = $signed({1'b0, sp_q}) - $signed({1'b0, pv_q});
        integ_sum = {integ_q[INTEG_W-1], integ_q}
                  + {{(INTEG_W+1-ERR_W){e_calc[ERR_W-1]}}, e_calc};
        if (integ_sum > LIM_P)
            integ_sat = LIM_P;
        else if (integ_sum < LIM_N)
            integ_sat = LIM_N;
        else
            integ_sat = integ_sum;

        // ERR clears and arms the MAC; the last P step re-arms it for the I pass.
        mac_clear  = (state == ERR);
        mac_start  = (state == ERR) || ((state == MUL_P) && mac_done);
        mac_mcand  = (state == MUL_I) ? integ_q
                                      : {{(INTEG_W-ERR_W){e_q[ERR_W-1]}}, e_q};
        mac_mplier = (state == MUL_I) ? ki_q : kp_q;

        r = mac_acc >>> FRAC_BITS;
    end

    shift_add_mac u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clear),
        .start  (mac_start),
        .mcand  (mac_mcand),
        .mplier (mac_mplier),
        .acc    (mac_acc),
        .done   (mac_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sp_q       <= '0;
            pv_q       <= '0;
            kp_q       <= '0;
            ki_q       <= '0;
            e_q        <= '0;
            integ_q    <= '0;
            stimulus_q <= '0;
            stim_stb_q <= 1'b0;
        end else begin
            stim_stb_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.pv_stb) begin
                        sp_q  <= bus.sp;
                        pv_q  <= bus.pv;
                        kp_q  <= bus.kp;
                        ki_q  <= bus.ki;
                        state <= ERR;
                    end
                end
                ERR: begin
                    e_q     <= e_calc;
                    integ_q <= integ_sat[INTEG_W-1:0];
                    state   <= MUL_P;
                end
                MUL_P: if (mac_done) state <= MUL_I;
                MUL_I: if (mac_done) state <= SUM;
                SUM: begin
                    if (r[ACC_W-1])
                        stimulus_q <= 8'd0;
                    else if (r > STIM_MAX)
                        stimulus_q <= 8'd255;
                    else
                        stimulus_q <= r[7:0];
                    stim_stb_q <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stimulus = stimulus_q;
    assign bus.stim_stb = stim_stb_q;
    assign bus.busy     = (state != IDLE);
endmodule
